aes_key_expand_mem: RTL
=======================

Name: aes_key_expand_mem

Overview:
Key expansion and round-key store feeding the AES decipher (and encipher) round block. On init it expands a 128- or 256-bit cipher key into 11 or 15 round keys, one round key per cycle, using an external shared forward S-box. Round keys sit in a 15-entry register memory. The round block reads them by round index, combinationally and in any order; the decipher block reads descending from 10 or 14 down to 0.

Parameters:
- NUM_KEYS, 15, depth of the round-key memory (entries 0..14); fixed for AES-256.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset; asynchronous, active-low
- init  in  1  single-cycle pulse that starts expansion; honoured only while ready=1
- key  in  256  cipher key; AES-128 uses key[255:128], key[127:0] is don't-care
- keylen  in  1  0 = AES-128, 1 = AES-256
- round  in  4  read index
- round_key  out  128  combinational read of mem[round]
- ready  out  1  1 = idle and memory valid
- sboxw  out  32  word sent to the shared forward S-box
- new_sboxw  in  32  S-box result, combinational return

Behaviour:
- Reset (async, reset_n=0):
  - all memory entries = 0, ready = 1, state = IDLE, counter = 0, rcon = 8'h01, key_reg = 0, keylen_reg = 0.
  - sboxw = 0 outside GEN.
- States:
  - IDLE: init=1 latches key→key_reg and keylen→keylen_reg, sets ready<=0, goes to INIT.
  - INIT (one cycle):
    - mem[0] <= key_reg[255:128].
    - If keylen_reg=1, mem[1] <= key_reg[127:0].
    - ctr <= 1 (128) or 2 (256); rcon <= 8'h01; go to GEN.
  - GEN (one cycle per key):
    - writes mem[ctr] <= new key; ctr++.
    - When ctr == 10 (128) or 14 (256), writes the final key, ready<=1, goes to IDLE.
- Key math: p = mem[ctr-1], q = mem[ctr-2]; words are w0 = [127:96] .. w3 = [31:0].
  - AES-128: sboxw = RotWord(p.w3) = {p.w3[23:0], p.w3[31:24]}; t = new_sboxw ^ {rcon, 24'h0}; base = p.
  - AES-256, ctr even: sboxw = RotWord(p.w3); t = new_sboxw ^ {rcon, 24'h0}; base = q.
  - AES-256, ctr odd: sboxw = p.w3 (no rotate, no rcon); t = new_sboxw; base = q.
  - n0 = base.w0 ^ t; n1 = base.w1 ^ n0; n2 = base.w2 ^ n1; n3 = base.w3 ^ n2.
  - rcon advances by xtime (rcon<<1 ^ (8'h1b if rcon[7])) after every use: 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
- Latency (init sampled at edge E0):
  - AES-128: INIT at E1, keys 1..10 at E2..E11; ready=1 after E11 (11 cycles busy).
  - AES-256: keys 2..14 at E2..E14; ready=1 after E14.
- Boundary conditions:
  - init while ready=0: ignored; no restart and key not relatched.
  - key/keylen changes after the init cycle: no effect on the current expansion.
  - round = 15: round_key = 0.
  - round read while ready=0: returns current memory contents, possibly partial; the consumer gates on ready.
  - AES-128 indices 11..14: stale contents retained unless the optional feature below is compiled in.
  - reset mid-expansion: immediate return to the reset state; memory cleared.
  - init in the same cycle as reset release: ignored (reset dominates).

Optional Feature:
- Macro: AES_KEY_MEM_ZEROIZE_EN.
- Defined: at the INIT cycle, every entry not produced for the new keylen is cleared to 0. That is entries 11..14 in 128 mode, and entries 1..14 before generation in both modes. It guarantees no residue from a prior key.
- Undefined: entries not written by the current expansion keep prior values.

Decomposition:
- Shared package aes_pkg: AES_128_BIT_KEY=1'b0, AES_256_BIT_KEY=1'b1, AES128_ROUNDS=4'ha, AES256_ROUNDS=4'he, RCON_INIT=8'h01, key-mem state encodings (IDLE/INIT/GEN), xtime/gm2 function.
- No internal sub-module. The forward S-box (aes_sbox) stays external so encipher and key expansion share one instance.

Test Plan:
- Reset check: reset_n=0 → ready=1, round_key=0 for all round 0..15, sboxw=0.
- FIPS-197 AES-128: key[255:128]=000102030405060708090a0b0c0d0e0f, keylen=0, init pulse → ready low 11 cycles. Then round=0 → 000102..0f, round=10 → 13111d7fe3944a17f307a78b4d2b30c5.
- FIPS-197 AES-256: key=000102..1f, keylen=1 → ready low 14 cycles. Then round=1 → 101112..1f, round=14 → 24fc79ccbf0979e9371ac23c6d68de36.
- init re-pulse mid-expansion with a different key → ignored; final round 10 key matches the first key.
- reset_n asserted at GEN cycle 5 → ready=1 and all entries 0 immediately; a subsequent init completes correctly.
- Run AES-256, then AES-128 → with AES_KEY_MEM_ZEROIZE_EN, round=12 reads 0; without it, round=12 reads the AES-256 value.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES constants, key-memory FSM state encodings and the GF(2^8)
// doubling helper used by the key expansion round-constant sequence.
package aes_pkg;

    localparam logic       AES_128_BIT_KEY = 1'b0;
    localparam logic       AES_256_BIT_KEY = 1'b1;
    localparam logic [3:0] AES128_ROUNDS   = 4'ha;
    localparam logic [3:0] AES256_ROUNDS   = 4'he;
    localparam logic [7:0] RCON_INIT       = 8'h01;

    // Key-memory controller states
    typedef enum logic [1:0] {
        KM_IDLE = 2'd0,
        KM_INIT = 2'd1,
        KM_GEN  = 2'd2
    } key_mem_state_e;

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] gm2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_key_expand_mem_if.sv
// Bundle between the key expansion store, its consumer (round block /
// controller) and the shared forward S-box.
interface aes_key_expand_mem_if;
    logic         init;
    logic [255:0] key;
    logic         keylen;
    logic [3:0]   round;
    logic [127:0] round_key;
    logic         ready;
    logic [31:0]  sboxw;
    logic [31:0]  new_sboxw;

    // Consumer side: starts expansion, reads keys, returns S-box results
    modport master (
        output init, key, keylen, round, new_sboxw,
        input  round_key, ready, sboxw
    );

    // Key expansion store side
    modport slave (
        input  init, key, keylen, round, new_sboxw,
        output round_key, ready, sboxw
    );
endinterface

// File: rtl/aes_key_expand_mem.sv
// AES-128/256 key expansion with a 15-entry round-key register memory.
// One round key is produced per cycle using an external shared S-box.
// Optional build macro: AES_KEY_MEM_ZEROIZE_EN -- when defined, the INIT
// cycle clears every entry the new expansion does not write up front, so
// no round key from a previous cipher key survives.
module aes_key_expand_mem
    import aes_pkg::*;
#(
    parameter int NUM_KEYS = 15
) (
    input logic                 clk,
    input logic                 reset_n,
    aes_key_expand_mem_if.slave kif
);

    key_mem_state_e state_q, state_d;
    logic [3:0]     ctr_q, ctr_d;
    logic [7:0]     rcon_q, rcon_d;
    logic [255:0]   key_q, key_d;
    logic           keylen_q, keylen_d;
    logic           ready_q, ready_d;
    logic [127:0]   mem_q [NUM_KEYS];
    logic [127:0]   mem_d [NUM_KEYS];

    logic [3:0]     p_idx;
    logic [3:0]     q_idx;
    logic [127:0]   p_key;
    logic [127:0]   q_key;
    logic [127:0]   base_key;
    logic           odd_256;
    logic [31:0]    sboxw_w;
    logic [31:0]    t_word;
    logic [31:0]    n0, n1, n2, n3;
    logic [127:0]   new_key;
    logic [3:0]     final_ctr;

    // Round-key math for the entry being generated (index ctr_q)
    always_comb begin
        p_idx    = ctr_q - 4'd1;
        q_idx    = (ctr_q >= 4'd2) ? (ctr_q - 4'd2) : 4'd0;
        p_key    = mem_q[p_idx];
        q_key    = mem_q[q_idx];
        // AES-256 odd keys use SubWord only: no rotate, no round constant
        odd_256  = (keylen_q == AES_256_BIT_KEY) && ctr_q[0];
        base_key = (keylen_q == AES_256_BIT_KEY) ? q_key : p_key;
        sboxw_w  = 32'h0;
        if (state_q == KM_GEN) begin
            sboxw_w = odd_256 ? p_key[31:0] : {p_key[23:0], p_key[31:24]};
        end
        t_word    = odd_256 ? kif.new_sboxw : (kif.new_sboxw ^ {rcon_q, 24'h0});
        n0        = base_key[127:96] ^ t_word;
        n1        = base_key[95:64]  ^ n0;
        n2        = base_key[63:32]  ^ n1;
        n3        = base_key[31:0]   ^ n2;
        new_key   = {n0, n1, n2, n3};
        final_ctr = (keylen_q == AES_256_BIT_KEY) ? AES256_ROUNDS : AES128_ROUNDS;
    end

    // Controller next-state and memory write selection
    always_comb begin
        state_d  = state_q;
        ctr_d    = ctr_q;
        rcon_d   = rcon_q;
        key_d    = key_q;
        keylen_d = keylen_q;
        ready_d  = ready_q;
        for (int i = 0; i < NUM_KEYS; i++) begin
            mem_d[i] = mem_q[i];
        end
        case (state_q)
            KM_IDLE: begin
                if (kif.init) begin
                    key_d    = kif.key;
                    keylen_d = kif.keylen;
                    ready_d  = 1'b0;
                    state_d  = KM_INIT;
                end
            end
            KM_INIT: begin
`ifdef AES_KEY_MEM_ZEROIZE_EN
                for (int i = 1; i < NUM_KEYS; i++) begin
                    mem_d[i] = '0;
                end
`endif
                mem_d[0] = key_q[255:128];
                if (keylen_q == AES_256_BIT_KEY) begin
                    mem_d[1] = key_q[127:0];
                    ctr_d    = 4'd2;
                end else begin
                    ctr_d    = 4'd1;
                end
                rcon_d  = RCON_INIT;
                state_d = KM_GEN;
            end
            KM_GEN: begin
                mem_d[ctr_q] = new_key;
                ctr_d        = ctr_q + 4'd1;
                if (!odd_256) begin
                    rcon_d = gm2(rcon_q);
                end
                if (ctr_q == final_ctr) begin
                    ready_d = 1'b1;
                    state_d = KM_IDLE;
                end
            end
            default: begin
                state_d = KM_IDLE;
            end
        endcase
    end

    // Controller registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= KM_IDLE;
            ctr_q    <= 4'd0;
            rcon_q   <= RCON_INIT;
            key_q    <= '0;
            keylen_q <= AES_128_BIT_KEY;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            ctr_q    <= ctr_d;
            rcon_q   <= rcon_d;
            key_q    <= key_d;
            keylen_q <= keylen_d;
            ready_q  <= ready_d;
        end
    end

    // Round-key memory: one cleared-on-reset register per entry
    generate
        for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_mem
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    mem_q[gi] <= '0;
                end else begin
                    mem_q[gi] <= mem_d[gi];
                end
            end
        end
    endgenerate

    // Index 15 has no storage behind it and reads as zero
    assign kif.round_key = (kif.round < 4'(NUM_KEYS)) ? mem_q[kif.round] : '0;
    assign kif.ready     = ready_q;
    assign kif.sboxw     = sboxw_w;

endmodule
